// File: rtl/funnel_arb_if.sv
// Requester/consumer bundle for funnel_arb: two request channels in, one result channel out.
interface funnel_arb_if;
   logic       v0;
   logic       v1;
   logic       r0;
   logic       r1;
   logic [7:0] i0;
   logic [7:0] i1;
   logic [2:0] f0;
   logic [2:0] f1;
   logic [7:0] s0;
   logic [7:0] s1;
   logic       ov;
   logic       ordy;
   logic [7:0] o;
   logic       oid;
   logic       err;

   modport master (
      output v0, v1, i0, i1, f0, f1, s0, s1, ordy,
      input  r0, r1, ov, o, oid, err
   );

   modport slave (
      input  v0, v1, i0, i1, f0, f1, s0, s1, ordy,
      output r0, r1, ov, o, oid, err
   );
endinterface

// File: rtl/funnel_arb.sv
// Two-requester round-robin arbiter in front of one shared 8-bit funnel shifter with a single-entry result stage.
// Define FUNNEL_ARB_STAT_EN to add per-requester transfer counters cnt0/cnt1.
module funnel_arb (
   input  logic              clk,
   input  logic              rst,
   funnel_arb_if.slave       bus
`ifdef FUNNEL_ARB_STAT_EN
   ,
   output logic [7:0]        cnt0,
   output logic [7:0]        cnt1
`endif
);

   typedef enum logic {ST_EMPTY, ST_FULL} stage_t;

   stage_t     st_reg, st_next;
   logic       ptr_reg, ptr_next;
   logic [7:0] o_reg, o_next;
   logic       oid_reg, oid_next;
   logic       err_reg, err_next;

   logic       stage_free;
   logic       g0, g1, grant;
   logic [7:0] sel_i, sel_s;
   logic [2:0] sel_f;
   logic [3:0] amt;
   logic [15:0] dbl, rot_r, rot_l;
   logic [7:0] ar_res;
   logic [7:0] sh_res;
   logic       sh_err;

   // Arbitration: contention resolved by the pointer, a lone requester always wins.
   always_comb begin
      stage_free = (st_reg == ST_EMPTY) || bus.ordy;
      g0 = !rst && bus.v0 && stage_free && (!bus.v1 || !ptr_reg);
      g1 = !rst && bus.v1 && stage_free && (!bus.v0 ||  ptr_reg);
   end

   assign grant = g0 | g1;

   assign sel_i = g1 ? bus.i1 : bus.i0;
   assign sel_f = g1 ? bus.f1 : bus.f0;
   assign sel_s = g1 ? bus.s1 : bus.s0;

   // Rotates come from a doubled word so an amount of 8 naturally returns the operand.
   assign amt    = sel_s[3:0];
   assign dbl    = {sel_i, sel_i};
   assign rot_r  = dbl >> amt;
   assign rot_l  = dbl << amt;
   assign ar_res = $signed(sel_i) >>> amt;
   assign sh_err = (sel_s > 8'd8);

   always_comb begin
      sh_res = 8'h00;
      case (sel_f)
         3'b000:         sh_res = sel_i >> amt;
         3'b001, 3'b011: sh_res = sel_i << amt;
         3'b010:         sh_res = ar_res;
         3'b100:         sh_res = rot_r[7:0];
         default:        sh_res = rot_l[15:8];
      endcase
      if (sh_err) begin
         sh_res = 8'h00;
      end
   end

   always_comb begin
      st_next  = st_reg;
      ptr_next = ptr_reg;
      o_next   = o_reg;
      oid_next = oid_reg;
      err_next = err_reg;
      if (grant) begin
         st_next  = ST_FULL;
         o_next   = sh_res;
         oid_next = g1;
         err_next = sh_err;
         ptr_next = g0;
      end else if (bus.ordy) begin
         st_next = ST_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_reg  <= ST_EMPTY;
         ptr_reg <= 1'b0;
         o_reg   <= 8'h00;
         oid_reg <= 1'b0;
         err_reg <= 1'b0;
      end else begin
         st_reg  <= st_next;
         ptr_reg <= ptr_next;
         o_reg   <= o_next;
         oid_reg <= oid_next;
         err_reg <= err_next;
      end
   end

   assign bus.r0  = g0;
   assign bus.r1  = g1;
   assign bus.ov  = (st_reg == ST_FULL);
   assign bus.o   = o_reg;
   assign bus.oid = oid_reg;
   assign bus.err = err_reg;

`ifdef FUNNEL_ARB_STAT_EN
   logic [7:0] cnt0_reg, cnt1_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt0_reg <= 8'h00;
         cnt1_reg <= 8'h00;
      end else begin
         if (g0) cnt0_reg <= cnt0_reg + 8'd1;
         if (g1) cnt1_reg <= cnt1_reg + 8'd1;
      end
   end

   assign cnt0 = cnt0_reg;
   assign cnt1 = cnt1_reg;
`endif

endmodule

// File: tb/tb_funnel_arb.sv
// Directed plus randomized bench for funnel_arb against a behavioural arbitration/shift model.
module tb_funnel_arb;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   funnel_arb_if bus();

`ifdef FUNNEL_ARB_STAT_EN
   logic [7:0] cnt0, cnt1;
`endif

   funnel_arb dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef FUNNEL_ARB_STAT_EN
      ,
      .cnt0 (cnt0),
      .cnt1 (cnt1)
`endif
   );

   int vectors = 0;
   int miscompares = 0;

   logic       m_ov = 1'b0, m_oid = 1'b0, m_err = 1'b0, m_ptr = 1'b0;
   logic [7:0] m_o = 8'h00;
   logic [7:0] m_cnt0 = 8'h00, m_cnt1 = 8'h00;
   logic       last_r0, last_r1, last_g0, last_g1;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Shift result computed one bit position at a time with plain integer arithmetic.
   function automatic void ref_shift(input logic [7:0] i, input logic [2:0] f,
                                     input logic [7:0] s, output logic [7:0] o,
                                     output logic e);
      int x;
      x = int'(i);
      if (s > 8) begin
         o = 8'h00;
         e = 1'b1;
         return;
      end
      e = 1'b0;
      for (int k = 0; k < int'(s); k++) begin
         case (f)
            3'd0:       x = x / 2;
            3'd1, 3'd3: x = (x * 2) % 256;
            3'd2:       x = x / 2 + ((x >= 128) ? 128 : 0);
            3'd4:       x = x / 2 + (x % 2) * 128;
            default:    x = (x * 2) % 256 + x / 128;
         endcase
      end
      o = x[7:0];
   endfunction

   // One clock: check grants mid-cycle, advance the model at the edge, check the result stage after it.
   task automatic cycle();
      logic [7:0] ro;
      logic       re;
      logic       free, want0, want1;
      @(negedge clk);
      free  = !m_ov || bus.ordy;
      want0 = 1'b0;
      want1 = 1'b0;
      if (!rst && free) begin
         if (bus.v0 && bus.v1) begin
            if (m_ptr) want1 = 1'b1;
            else       want0 = 1'b1;
         end else if (bus.v0) begin
            want0 = 1'b1;
         end else if (bus.v1) begin
            want1 = 1'b1;
         end
      end
      last_r0 = bus.r0;
      last_r1 = bus.r1;
      last_g0 = want0;
      last_g1 = want1;
      chk("r0", bus.r0, want0);
      chk("r1", bus.r1, want1);
      @(posedge clk);
      if (rst) begin
         m_ov = 0; m_o = 0; m_oid = 0; m_err = 0; m_ptr = 0;
         m_cnt0 = 0; m_cnt1 = 0;
      end else if (want0 || want1) begin
         if (want0) ref_shift(bus.i0, bus.f0, bus.s0, ro, re);
         else       ref_shift(bus.i1, bus.f1, bus.s1, ro, re);
         m_ov  = 1'b1;
         m_o   = ro;
         m_err = re;
         m_oid = want1;
         m_ptr = want0;
         if (want0) m_cnt0 = m_cnt0 + 8'd1;
         else       m_cnt1 = m_cnt1 + 8'd1;
      end else if (bus.ordy) begin
         m_ov = 1'b0;
      end
      #1;
      chk("ov", bus.ov, m_ov);
      if (m_ov || rst) begin
         chk("o", bus.o, m_o);
         chk("oid", bus.oid, m_oid);
         chk("err", bus.err, m_err);
      end
`ifdef FUNNEL_ARB_STAT_EN
      chk("cnt0", cnt0, m_cnt0);
      chk("cnt1", cnt1, m_cnt1);
`endif
   endtask

   logic [7:0] held_o;
   logic       pend0, pend1;

   initial begin
      rst = 1'b1;
      bus.v0 = 1'b1; bus.v1 = 1'b1; bus.ordy = 1'b0;
      bus.i0 = 8'h00; bus.i1 = 8'h00; bus.f0 = 3'd0; bus.f1 = 3'd0;
      bus.s0 = 8'd0;  bus.s1 = 8'd0;
      cycle();
      cycle();

      // Single request after reset
      rst = 1'b0;
      bus.v1 = 1'b0;
      bus.v0 = 1'b1; bus.i0 = 8'h81; bus.f0 = 3'b000; bus.s0 = 8'd1; bus.ordy = 1'b1;
      cycle();
      chk("r0_single", last_r0, 1'b1);
      chk("o_single", bus.o, 8'h40);
      chk("oid_single", bus.oid, 1'b0);
      chk("err_single", bus.err, 1'b0);
      bus.v0 = 1'b0;
      cycle();

      // Contention with rotate right by 4
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      bus.v0 = 1'b1; bus.v1 = 1'b1;
      bus.f0 = 3'b100; bus.f1 = 3'b100; bus.s0 = 8'd4; bus.s1 = 8'd4;
      bus.i0 = 8'hA5; bus.i1 = 8'h3C;
      cycle();
      chk("r0_rr", last_r0, 1'b1);
      chk("o_rr0", bus.o, 8'h5A);
      chk("oid_rr0", bus.oid, 1'b0);
      bus.v0 = 1'b0;
      cycle();
      chk("r1_rr", last_r1, 1'b1);
      chk("o_rr1", bus.o, 8'hC3);
      chk("oid_rr1", bus.oid, 1'b1);
      bus.v1 = 1'b0;
      cycle();

      // Backpressure, then back-to-back drain
      bus.v0 = 1'b1; bus.i0 = 8'h12; bus.f0 = 3'b100; bus.s0 = 8'd3; bus.ordy = 1'b1;
      cycle();
      held_o = bus.o;
      bus.i0 = 8'h34;
      bus.v1 = 1'b1; bus.i1 = 8'h56; bus.f1 = 3'b001; bus.s1 = 8'd2;
      bus.ordy = 1'b0;
      repeat (3) begin
         cycle();
         chk("r0_bp", last_r0, 1'b0);
         chk("r1_bp", last_r1, 1'b0);
         chk("o_bp", bus.o, held_o);
      end
      bus.ordy = 1'b1;
      cycle();
      chk("r1_release", last_r1, 1'b1);
      chk("o_release", bus.o, 8'h58);
      chk("oid_release", bus.oid, 1'b1);
      bus.v1 = 1'b0;
      cycle();
      chk("ov_b2b", bus.ov, 1'b1);
      chk("o_b2b", bus.o, 8'h86);
      chk("oid_b2b", bus.oid, 1'b0);
      bus.v0 = 1'b0;
      cycle();

      // Shift amount boundaries
      bus.v0 = 1'b1; bus.i0 = 8'h80; bus.f0 = 3'b010; bus.s0 = 8'd8;
      cycle();
      chk("o_s8", bus.o, 8'hFF);
      chk("err_s8", bus.err, 1'b0);
      bus.f0 = 3'b101; bus.s0 = 8'd9;
      cycle();
      chk("o_s9", bus.o, 8'h00);
      chk("err_s9", bus.err, 1'b1);
      bus.v0 = 1'b0;
      cycle();

      // Reset discards a stalled result and restores requester-0 priority
      bus.v0 = 1'b1; bus.i0 = 8'h01; bus.f0 = 3'b000; bus.s0 = 8'd0; bus.ordy = 1'b0;
      cycle();
      bus.v0 = 1'b0;
      cycle();
      chk("ov_stall", bus.ov, 1'b1);
      rst = 1'b1;
      cycle();
      chk("ov_rst", bus.ov, 1'b0);
      rst = 1'b0;
      bus.v0 = 1'b1; bus.v1 = 1'b1;
      cycle();
      chk("r0_after_rst", last_r0, 1'b1);
      bus.v0 = 1'b0; bus.ordy = 1'b1;
      cycle();
      bus.v1 = 1'b0;
      cycle();

      // Randomized traffic; pending requests keep their operands until granted
      pend0 = 1'b0;
      pend1 = 1'b0;
      for (int n = 0; n < 500; n++) begin
         if (!pend0) begin
            bus.v0 = 1'($urandom_range(0, 1));
            bus.i0 = 8'($urandom_range(0, 255));
            bus.f0 = 3'($urandom_range(0, 7));
            bus.s0 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                 : 8'($urandom_range(0, 9));
         end
         if (!pend1) begin
            bus.v1 = 1'($urandom_range(0, 1));
            bus.i1 = 8'($urandom_range(0, 255));
            bus.f1 = 3'($urandom_range(0, 7));
            bus.s1 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                 : 8'($urandom_range(0, 9));
         end
         rst      = ($urandom_range(0, 99) == 0);
         bus.ordy = ($urandom_range(0, 3) != 0);
         cycle();
         pend0 = (last_g0 || rst) ? 1'b0 : bus.v0;
         pend1 = (last_g1 || rst) ? 1'b0 : bus.v1;
      end
      rst = 1'b0;
      bus.v0 = 1'b0; bus.v1 = 1'b0; bus.ordy = 1'b1;
      cycle();

`ifdef FUNNEL_ARB_STAT_EN
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      bus.v0 = 1'b1; bus.v1 = 1'b0; bus.ordy = 1'b1;
      repeat (256) cycle();
      chk("cnt0_wrap", cnt0, 8'h00);
      chk("cnt1_idle", cnt1, 8'h00);
      bus.v0 = 1'b0;
      cycle();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/funnel_arb.md
FUNNEL_ARB -- requirements
Module: funnel_arb

Interface
REQ-001 The module SHALL have no parameters; all widths SHALL be fixed as listed.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 v0 / v1  input  1  request valid, requester 0 / 1.
REQ-005 r0 / r1  output  1  request ready (grant), requester 0 / 1; combinational.
REQ-006 i0 / i1  input  8  operand data, requester 0 / 1.
REQ-007 f0 / f1  input  3  function code, requester 0 / 1.
REQ-008 s0 / s1  input  8  shift amount, requester 0 / 1.
REQ-009 ov  output  1  result valid.
REQ-010 ordy  input  1  result consumer ready.
REQ-011 o  output  8  result data.
REQ-012 oid  output  1  index of the requester that owns the result.
REQ-013 err  output  1  result is an out-of-range error, not a shift.

Function
REQ-014 The block SHALL share one 8-bit funnel shifter between two requesters, with a one-entry registered result stage.
REQ-015 Shift results for s in 0..7: f=000 logical right; f=001 and f=011 logical left; f=010 arithmetic right, sign-filled from i[7]; f=100 rotate right; f=101, 110, 111 rotate left.
REQ-016 For s=8: logical right and logical left SHALL give 8'h00; arithmetic right SHALL give {8{i[7]}}; rotate right and rotate left SHALL give i. err SHALL be 0.
REQ-017 For s>8: the result SHALL be o=8'h00 and err=1, with no shift performed.
REQ-018 The result stage SHALL be free when ov=0, or when ov=1 and ordy=1 in the same cycle.
REQ-019 A grant SHALL be issued only while the result stage is free; at most one requester SHALL be granted per cycle.
REQ-020 r0 SHALL be v0 AND (stage free) AND (v1=0 OR the priority pointer selects requester 0); r1 SHALL follow symmetrically.
REQ-021 Transfer SHALL occur when vN=1 and rN=1; the requester SHALL hold iN, fN and sN stable while vN=1 and rN=0.
REQ-022 Latency: a request accepted in cycle N SHALL appear with ov=1 and the matching o, oid and err in cycle N+1.
REQ-023 ov, o, oid and err SHALL hold stable while ov=1 and ordy=0.
REQ-024 If ov=1, ordy=1 and a new grant occur in the same cycle, the stage SHALL reload with no bubble cycle.
REQ-025 If ov=1, ordy=1 and there is no grant, ov SHALL go to 0 on the next cycle.
REQ-026 A 1-bit round-robin pointer SHALL toggle to the non-granted requester after every transfer, and SHALL be unchanged otherwise.
REQ-027 A single valid requester SHALL be granted regardless of the pointer value.

Reset
REQ-028 While rst=1 at a clock edge: ov=0, o=8'h00, oid=0, err=0, pointer=0 (requester 0 has priority).
REQ-029 While rst=1, r0 and r1 SHALL be 0.
REQ-030 A result pending at reset SHALL be discarded, not delivered.

Configuration
REQ-031 Macro FUNNEL_ARB_STAT_EN defined: the block SHALL add outputs cnt0 and cnt1 (8 bits each).
REQ-032 cnt0 / cnt1 SHALL count completed transfers of requester 0 / 1, wrap from 8'hFF to 8'h00, and clear on reset.
REQ-033 Macro undefined: cnt0, cnt1 and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-034 After reset: v0=1, i0=8'h81, f0=000, s0=1, ordy=1 -> r0=1 same cycle; next cycle ov=1, o=8'h40, oid=0, err=0.
REQ-035 Both valid after reset, f=100, s=4, i0=8'hA5, i1=8'h3C, ordy=1 -> grants r0 then r1 on consecutive cycles; results o=8'h5A (oid=0), then o=8'hC3 (oid=1).
REQ-036 Backpressure: ordy=0 for 3 cycles with ov=1 -> r0=r1=0 and o stable; ordy=1 -> pending requester granted in that same cycle, back-to-back output.
REQ-037 Boundaries: i=8'h80, f=010, s=8 -> o=8'hFF, err=0; i=8'h80, f=101, s=9 -> o=8'h00, err=1.
REQ-038 rst asserted while ov=1 and ordy=0 -> next cycle ov=0 and pointer=0; with FUNNEL_ARB_STAT_EN, 256 requester-0 transfers -> cnt0=8'h00.
